// File: rtl/dmem_responder.sv
// Word-organised data-memory target for the core load/store port: one request at a time, response held until taken.
// Latency: request accepted at edge T0, access on edge T0+LATENCY, resp_valid high from that edge until retired.
// Backpressure: req_ready only in IDLE; response (rdata/err) held stable while resp_ready is low.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   req_valid/ready   request handshake; req_we, req_addr (byte address), req_wdata
//   req_wstrb         byte-lane write strobes, present only when DMEM_WSTRB_EN is defined
//   resp_valid/ready  response handshake; resp_rdata (0 for stores/faults), resp_err (misaligned/out of range)
// Parameters: DEPTH words of 32 bits; LATENCY wait cycles, 0..15.
// Build option: define DMEM_WSTRB_EN for per-lane store strobes; otherwise every store writes the full word.
module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
`ifdef DMEM_WSTRB_EN
    input  logic [3:0]  req_wstrb,
`endif
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // The wait counter counts down to zero, so the reload value is one less than the wait length.
    localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH];

    // Access-side view: either the latched request, or the live request when LATENCY is zero.
    logic             acc_en;
    logic             acc_we;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    logic [3:0]       acc_wstrb;
    logic             acc_fault;
    logic [IDX_W-1:0] acc_idx;
    logic             mem_wr;
    logic [3:0]       req_strb;

`ifdef DMEM_WSTRB_EN
    assign req_strb = req_wstrb;
`else
    assign req_strb = 4'hF;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        acc_en    = 1'b0;
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_wstrb = wstrb_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_strb;
                    cnt_d   = CNT_INIT;
                    if (LATENCY == 0) begin
                        // Zero-wait: the access happens on the accept edge using the live request.
                        acc_en    = 1'b1;
                        acc_we    = req_we;
                        acc_addr  = req_addr;
                        acc_wdata = req_wdata;
                        acc_wstrb = req_strb;
                        state_d   = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    acc_en  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                // Retire only; a request cannot be taken on this same edge.
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        acc_idx   = acc_addr[IDX_W+1:2];
        acc_fault = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= 30'(DEPTH));
        mem_wr    = acc_en & acc_we & ~acc_fault & ~reset;

        if (acc_en) begin
            err_d   = acc_fault;
            rdata_d = (acc_fault || acc_we) ? 32'd0 : mem[acc_idx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM contents survive reset; a store is committed only on its access edge.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wstrb[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign req_ready  = (state_q == IDLE) & ~reset;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int DEP = 64;
    localparam int LAT = 2;
`ifdef DMEM_WSTRB_EN
    localparam bit STRB_EN = 1'b1;
`else
    localparam bit STRB_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int total = 0;
    int bad   = 0;

    dmem_responder #(.DEPTH(DEP), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
`ifdef DMEM_WSTRB_EN
        .req_wstrb  (req_wstrb),
`endif
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    localparam int M_IDLE = 0, M_BUSY = 1, M_RESP = 2;
    int          m_state   = M_IDLE;
    int          cyc       = 0;
    int          m_due     = 0;
    int          m_accepts = 0;
    bit          m_fresh   = 1'b1;
    logic [31:0] m_rdata   = 32'd0;
    logic        m_err     = 1'b0;
    logic [31:0] model_mem [DEP];
    logic        p_we;
    logic [31:0] p_addr, p_wdata;
    logic [3:0]  p_strb;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state = M_IDLE;
            m_rdata = 32'd0;
            m_err   = 1'b0;
            m_fresh = 1'b1;
        end else begin
            cyc++;
            if (m_state == M_RESP && resp_ready) begin
                m_state = M_IDLE;
            end else if (m_state == M_IDLE && req_valid) begin
                p_we    = req_we;
                p_addr  = req_addr;
                p_wdata = req_wdata;
                p_strb  = STRB_EN ? req_wstrb : 4'hF;
                m_due   = cyc + LAT;
                m_state = M_BUSY;
                m_accepts++;
            end
            if (m_state == M_BUSY && cyc == m_due) begin
                int idx;
                idx     = int'(p_addr >> 2);
                m_fresh = 1'b0;
                m_state = M_RESP;
                if (p_addr[1:0] != 2'b00 || (p_addr >> 2) >= DEP) begin
                    m_err   = 1'b1;
                    m_rdata = 32'd0;
                end else begin
                    m_err = 1'b0;
                    if (p_we) begin
                        for (int i = 0; i < 4; i++)
                            if (p_strb[i]) model_mem[idx][8*i +: 8] = p_wdata[8*i +: 8];
                        m_rdata = 32'd0;
                    end else begin
                        m_rdata = model_mem[idx];
                    end
                end
            end
        end
    end

    // Compare process: outputs against the model on every falling edge outside reset.
    always @(negedge clk) begin
        if (!reset) begin
            check("req_ready", req_ready, (m_state == M_IDLE) ? 1 : 0);
            check("resp_valid", resp_valid, (m_state == M_RESP) ? 1 : 0);
            if (m_state == M_RESP || m_fresh) begin
                check("resp_rdata", resp_rdata, m_rdata);
                check("resp_err", resp_err, m_err);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int hold, input bit poke,
                          output logic [31:0] rdata, output logic err);
        int guard;
        int lat;
        rdata = 32'd0;
        err   = 1'b0;
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            check("req_ready_wait", req_ready, 1);
            return;
        end
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = strb;
        @(negedge clk);
        // Scramble the request bus: it must not matter after accept.
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_wstrb = 4'($urandom);
        lat = 1;
        while (!resp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!resp_valid) begin
            check("resp_valid_wait", resp_valid, 1);
            return;
        end
        check("latency", lat, LAT + 1);
        rdata = resp_rdata;
        err   = resp_err;
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                req_valid = 1'b1;
                req_we    = 1'($urandom);
                req_addr  = 32'($urandom_range(0, DEP - 1)) << 2;
                req_wdata = $urandom;
            end
            @(negedge clk);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] a;
        int          acc0;
        int          sel;

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_wstrb  = 4'hF;
        resp_ready = 1'b0;

        // 1: reset held, then released
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_resp_err", resp_err, 0);
        #2 reset = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", req_ready, 1);
        check("post_rst_resp_valid", resp_valid, 0);

        // Give every word a known value so the model tracks the whole RAM.
        for (int w = 0; w < DEP; w++) begin
            do_txn(1'b1, 32'(w) << 2, $urandom, 4'hF, 0, 1'b0, rd, er);
        end

        // 2: store then load with default latency
        do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, rd, er);
        check("store_rdata", rd, 32'h0);
        check("store_err", er, 0);
        do_txn(1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b0, rd, er);
        check("load_10_rdata", rd, 32'hDEADBEEF);
        check("load_10_err", er, 0);

        // 3: faults; a faulting store must not touch RAM
        do_txn(1'b0, 32'h12, 32'h0, 4'hF, 0, 1'b0, rd, er);
        check("misalign_err", er, 1);
        check("misalign_rdata", rd, 32'h0);
        do_txn(1'b0, 32'h100, 32'h0, 4'hF, 0, 1'b0, rd, er);
        check("range_err", er, 1);
        check("range_rdata", rd, 32'h0);
        do_txn(1'b1, 32'h11, 32'h55555555, 4'hF, 0, 1'b0, rd, er);
        check("misalign_store_err", er, 1);
        do_txn(1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b0, rd, er);
        check("load_10_after_fault", rd, 32'hDEADBEEF);

        // 4: response held for 5 cycles while new requests are offered
        acc0 = m_accepts;
        do_txn(1'b0, 32'h10, 32'h0, 4'hF, 5, 1'b1, rd, er);
        check("held_rdata", rd, 32'hDEADBEEF);
        check("held_accepts", m_accepts - acc0, 1);

        // 5: reset while a store is waiting drops the store
        do_txn(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 0, 1'b0, rd, er);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h12345678;
        req_wstrb = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        @(negedge clk);
        check("mid_rst_rdata", resp_rdata, 32'h0);
        do_txn(1'b0, 32'h20, 32'h0, 4'hF, 0, 1'b0, rd, er);
        check("dropped_store", rd, 32'hCAFEF00D);

`ifdef DMEM_WSTRB_EN
        // 6: partial-lane store
        do_txn(1'b1, 32'h8, 32'hAABBCCDD, 4'hF, 0, 1'b0, rd, er);
        do_txn(1'b1, 32'h8, 32'h11223344, 4'b0101, 0, 1'b0, rd, er);
        do_txn(1'b0, 32'h8, 32'h0, 4'hF, 0, 1'b0, rd, er);
        check("wstrb_merge", rd, 32'hAA22CC44);
        do_txn(1'b1, 32'h8, 32'h99999999, 4'b0000, 0, 1'b0, rd, er);
        do_txn(1'b0, 32'h8, 32'h0, 4'hF, 0, 1'b0, rd, er);
        check("wstrb_noop", rd, 32'hAA22CC44);
`endif

        // Streaming: request and response ready held high, throughput one per LAT+2 cycles
        @(negedge clk);
        resp_ready = 1'b1;
        acc0 = m_accepts;
        for (int i = 0; i < 40; i++) begin
            req_valid = 1'b1;
            req_we    = 1'($urandom);
            req_addr  = 32'($urandom_range(0, DEP - 1)) << 2;
            req_wdata = $urandom;
            req_wstrb = 4'($urandom);
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("stream_accepts", m_accepts - acc0, (40 + LAT + 1) / (LAT + 2));
        repeat (LAT + 3) @(negedge clk);
        resp_ready = 1'b0;

        // Randomized mix of loads, stores and faults with random response stalls
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)
                a = (32'($urandom_range(0, DEP - 1)) << 2) | 32'($urandom_range(1, 3));
            else if (sel == 1)
                a = $urandom | 32'h0000_0100;
            else
                a = 32'($urandom_range(0, DEP - 1)) << 2;
            do_txn(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3),
                   1'($urandom), rd, er);
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
